// File: rtl/bus_txn_queue.sv
// Bus transaction queue: packs {rw, addr, data} per accepted request into a show-ahead FIFO
// and tags each entry with a wrapping sequence number.
module bus_txn_queue #(
  parameter int unsigned AW    = 12,
  parameter int unsigned DW    = 12,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned PW   = 1 + AW + DW,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_rw_i,
  input  logic [AW-1:0]    in_addr_i,
  input  logic [DW-1:0]    in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [PW-1:0]    out_word_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  logic [PW-1:0]    mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];

  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;

  logic push, pop;

  // Handshake readiness depends on occupancy only, never on the opposite side.
  assign in_ready_o  = (count_q != Full);
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  assign out_word_o  = out_valid_o ? mem_q[rd_ptr_q]     : '0;
  assign out_tag_o   = out_valid_o ? tag_mem_q[rd_ptr_q] : '0;
  assign count_o     = count_q;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    tag_cnt_d = tag_cnt_q;
    if (flush_i) begin
      // Flush drops the offered push too; the tag counter keeps running across flushes.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PtrW'(1);
        tag_cnt_d = tag_cnt_q + TAG_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      tag_cnt_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      tag_cnt_q <= tag_cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mem_q[wr_ptr_q]     <= {in_rw_i, in_addr_i, in_data_i};
      tag_mem_q[wr_ptr_q] <= tag_cnt_q;
    end
  end

endmodule

// File: tb/tb_bus_txn_queue.sv
// Directed self-checking bench for bus_txn_queue with default parameters.
module tb_bus_txn_queue;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic        in_rw_i = 1'b0;
  logic [11:0] in_addr_i = '0;
  logic [11:0] in_data_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [24:0] out_word_o;
  logic [3:0]  out_tag_o;
  logic [2:0]  count_o;

  int n_checks = 0;
  int n_errors = 0;

  bus_txn_queue dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_rw_i     (in_rw_i),
    .in_addr_i   (in_addr_i),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_word_o  (out_word_o),
    .out_tag_o   (out_tag_o),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    flush_i     = 1'b0;
    rst_ni      = 1'b0;
    #3;
    rst_ni      = 1'b1;
    step();
  endtask

  task automatic set_in(input logic rw, input logic [11:0] addr, input logic [11:0] data);
    in_rw_i   = rw;
    in_addr_i = addr;
    in_data_i = data;
  endtask

  task automatic push_one(input logic rw, input logic [11:0] addr, input logic [11:0] data);
    set_in(rw, addr, data);
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
  endtask

  task automatic pop_one();
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
  endtask

  function automatic logic [24:0] mk(input logic rw, input logic [11:0] a, input logic [11:0] d);
    return {rw, a, d};
  endfunction

  initial begin
    #3;
    rst_ni = 1'b1;
    step();

    // 1: reset state and single push
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_in_ready",  32'(in_ready_o),  32'd1);
    check("rst_count",     32'(count_o),     32'd0);
    check("rst_out_word",  32'(out_word_o),  32'd0);
    check("rst_out_tag",   32'(out_tag_o),   32'd0);
    push_one(1'b1, 12'hA5C, 12'h3F1);
    check("t1_valid", 32'(out_valid_o), 32'd1);
    check("t1_word",  32'(out_word_o),  32'h1A5C3F1);
    check("t1_tag",   32'(out_tag_o),   32'd0);
    check("t1_count", 32'(count_o),     32'd1);
    pop_one();
    check("t1_drain_count", 32'(count_o), 32'd0);

    // 2: fill past full, then drain in order
    do_reset();
    in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(i[0], 12'(i), 12'(12'h100 + i));
      step();
      check("t2_fill_ready", 32'(in_ready_o), (i >= 3) ? 32'd0 : 32'd1);
    end
    in_valid_i = 1'b0;
    check("t2_full_count", 32'(count_o), 32'd4);
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_pop_tag",  32'(out_tag_o),  32'(i));
      check("t2_pop_word", 32'(out_word_o), 32'(mk(i[0], 12'(i), 12'(12'h100 + i))));
      step();
    end
    out_ready_i = 1'b0;
    check("t2_empty_count", 32'(count_o),     32'd0);
    check("t2_empty_word",  32'(out_word_o),  32'd0);
    check("t2_empty_valid", 32'(out_valid_o), 32'd0);

    // 3: steady stream with tag wrap
    do_reset();
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_in(k[0], 12'(k * 3), 12'(k + 7));
      if (k > 0) begin
        check("t3_count", 32'(count_o),   32'd1);
        check("t3_tag",   32'(out_tag_o), 32'((k - 1) % 16));
        check("t3_word",  32'(out_word_o), 32'(mk(k[0] ^ 1'b1, 12'((k - 1) * 3), 12'(k + 6))));
      end
      step();
    end
    in_valid_i = 1'b0;
    check("t3_last_tag",  32'(out_tag_o),  32'd3);
    check("t3_last_word", 32'(out_word_o), 32'(mk(1'b1, 12'd57, 12'd26)));
    step();
    out_ready_i = 1'b0;
    check("t3_end_count", 32'(count_o), 32'd0);

    // 4: single pop from full, refill lands behind remaining entries (tags continue at 4)
    for (int i = 0; i < 4; i++) push_one(1'b0, 12'(12'h200 + i), 12'(12'h300 + i));
    check("t4_full_count", 32'(count_o),    32'd4);
    check("t4_full_ready", 32'(in_ready_o), 32'd0);
    pop_one();
    check("t4_count_3", 32'(count_o),    32'd3);
    check("t4_ready_1", 32'(in_ready_o), 32'd1);
    push_one(1'b1, 12'hEEE, 12'hDDD);
    check("t4_refull", 32'(count_o), 32'd4);
    out_ready_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      check("t4_tag",  32'(out_tag_o),  32'(4 + i));
      check("t4_word", 32'(out_word_o), 32'(mk(1'b0, 12'(12'h200 + i), 12'(12'h300 + i))));
      step();
    end
    check("t4_new_tag",  32'(out_tag_o),  32'd8);
    check("t4_new_word", 32'(out_word_o), 32'h1EEEDDD);
    step();
    out_ready_i = 1'b0;
    check("t4_end_count", 32'(count_o), 32'd0);

    // 5: flush with a concurrent push does not consume a tag
    do_reset();
    for (int i = 0; i < 3; i++) push_one(1'b0, 12'(i), 12'(i));
    check("t5_count_3", 32'(count_o), 32'd3);
    set_in(1'b1, 12'h777, 12'h777);
    in_valid_i = 1'b1;
    flush_i    = 1'b1;
    #1;
    check("t5_ready_in_flush", 32'(in_ready_o), 32'd1);
    step();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("t5_flush_count", 32'(count_o),     32'd0);
    check("t5_flush_valid", 32'(out_valid_o), 32'd0);
    check("t5_flush_word",  32'(out_word_o),  32'd0);
    push_one(1'b1, 12'h123, 12'h456);
    check("t5_tag",   32'(out_tag_o),  32'd3);
    check("t5_word",  32'(out_word_o), 32'h1123456);
    check("t5_count", 32'(count_o),    32'd1);
    pop_one();

    // 6: asynchronous reset mid-cycle
    push_one(1'b1, 12'h0AA, 12'h055);
    push_one(1'b0, 12'h0BB, 12'h066);
    check("t6_count_2", 32'(count_o), 32'd2);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid_o), 32'd0);
    check("t6_async_count", 32'(count_o),     32'd0);
    check("t6_async_word",  32'(out_word_o),  32'd0);
    check("t6_async_tag",   32'(out_tag_o),   32'd0);
    #1;
    rst_ni = 1'b1;
    step();
    push_one(1'b0, 12'h321, 12'h654);
    check("t6_post_tag",  32'(out_tag_o),  32'd0);
    check("t6_post_word", 32'(out_word_o), 32'h0321654);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
